sram_bank: RTL and testbench



---
 rtl/sram_bank_if.sv | 26 ++
 rtl/sram_bank.sv | 167 ++++++++++++++++
 tb/tb_sram_bank.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_if.sv
// rtl/sram_bank_if.sv - request/response bundle between the buffer manager and one sram_bank
interface sram_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic              clear_req;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              rd_err;

    modport master (
        output clear_req, wr_en, wr_addr, din, rd_en, rd_addr,
        input  busy, dout, rd_valid, rd_err
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, din, rd_en, rd_addr,
        output busy, dout, rd_valid, rd_err
    );
endinterface

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - 1W/1R synchronous SRAM bank with bypass, range check and clear engine
module sram_bank #(
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 16384,
    parameter int              ADDR_W   = 14,
    parameter int              OUT_REG  = 0,
    parameter int              BYPASS   = 1,
    parameter int              INIT_EN  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    sram_bank_if.slave bus
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rdata_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_acc;
    logic              rd_hit;
    logic              wr_in_range;
    logic              rd_in_range;

    logic              rd_v1_q, rd_v1_d;
    logic              rd_err1_q, rd_err1_d;
    logic              rd_byp1_q, rd_byp1_d;
    logic [DATA_W-1:0] rd_din1_q, rd_din1_d;
    logic              rd_seen_q, rd_seen_d;
    logic [DATA_W-1:0] s1_data;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
    assign bus.busy    = (state_q == ST_INIT);

    // The clear engine and user writes share the single write port; clear_req wins in READY.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.din;
        rd_acc     = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = INIT_VAL;
                if (init_ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            default: begin
                if (bus.clear_req) begin
                    state_d    = ST_INIT;
                    init_ptr_d = '0;
                end else begin
                    mem_we = bus.wr_en && wr_in_range;
                    rd_acc = bus.rd_en;
                end
            end
        endcase
    end

    assign rd_hit = (BYPASS != 0) && mem_we && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        rd_v1_d   = rd_acc;
        rd_err1_d = rd_err1_q;
        rd_byp1_d = rd_byp1_q;
        rd_din1_d = rd_din1_q;
        rd_seen_d = rd_seen_q;
        if (rd_acc) begin
            rd_err1_d = !rd_in_range;
            rd_byp1_d = rd_hit;
            rd_din1_d = bus.din;
            rd_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (INIT_EN != 0) ? ST_INIT : ST_READY;
            init_ptr_q <= '0;
            rd_v1_q    <= 1'b0;
            rd_err1_q  <= 1'b0;
            rd_byp1_q  <= 1'b0;
            rd_din1_q  <= '0;
            rd_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rd_v1_q    <= rd_v1_d;
            rd_err1_q  <= rd_err1_d;
            rd_byp1_q  <= rd_byp1_d;
            rd_din1_q  <= rd_din1_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    // Array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_acc && rd_in_range) begin
            ram_rdata_q <= mem[bus.rd_addr];
        end
    end

    always_comb begin
        s1_data = ram_rdata_q;
        if (rd_byp1_q) begin
            s1_data = rd_din1_q;
        end
        if (rd_err1_q || !rd_seen_q) begin
            s1_data = '0;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            assign bus.dout     = s1_data;
            assign bus.rd_valid = rd_v1_q;
            assign bus.rd_err   = rd_v1_q & rd_err1_q;
        end else begin : g_outreg
            logic [DATA_W-1:0] dout_q, dout_d;
            logic              rd_v2_q, rd_v2_d;
            logic              rd_err2_q, rd_err2_d;

            always_comb begin
                dout_d    = rd_v1_q ? s1_data : dout_q;
                rd_v2_d   = rd_v1_q;
                rd_err2_d = rd_v1_q & rd_err1_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q    <= '0;
                    rd_v2_q   <= 1'b0;
                    rd_err2_q <= 1'b0;
                end else begin
                    dout_q    <= dout_d;
                    rd_v2_q   <= rd_v2_d;
                    rd_err2_q <= rd_err2_d;
                end
            end

            assign bus.dout     = dout_q;
            assign bus.rd_valid = rd_v2_q;
            assign bus.rd_err   = rd_err2_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_bank.sv
// tb/tb_sram_bank.sv - directed bench: two banks, latency 1 with bypass and latency 2 without
module tb_sram_bank;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DP = 10;
    localparam logic [DW-1:0] IV = 16'hA5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clear_req = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    sram_bank_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.clear_req = clear_req;
    assign if0.wr_en     = wr_en;
    assign if0.wr_addr   = wr_addr;
    assign if0.din       = din;
    assign if0.rd_en     = rd_en;
    assign if0.rd_addr   = rd_addr;
    assign if1.clear_req = clear_req;
    assign if1.wr_en     = wr_en;
    assign if1.wr_addr   = wr_addr;
    assign if1.din       = din;
    assign if1.rd_en     = rd_en;
    assign if1.rd_addr   = rd_addr;

    sram_bank #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .OUT_REG(0), .BYPASS(1),
                .INIT_EN(1), .INIT_VAL(IV)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sram_bank #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .OUT_REG(1), .BYPASS(0),
                .INIT_EN(1), .INIT_VAL(IV)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        clear_req = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; din = d;
        @(negedge clk);
        idle();
    endtask

    // Optional same-cycle write, then a read; e0/e1 are the results expected from dut0/dut1.
    task automatic access(input string tag, input bit we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                          input logic [DW-1:0] e0, input logic [DW-1:0] e1, input bit eerr);
        wr_en = we; wr_addr = wa; din = wd;
        rd_en = 1'b1; rd_addr = ra;
        @(negedge clk);
        idle();
        check_eq({tag, " v0@1"}, 32'(if0.rd_valid), 32'd1);
        check_eq({tag, " d0"},   32'(if0.dout), 32'(e0));
        check_eq({tag, " e0"},   32'(if0.rd_err), 32'(eerr));
        check_eq({tag, " v1@1"}, 32'(if1.rd_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, " v1@2"}, 32'(if1.rd_valid), 32'd1);
        check_eq({tag, " d1"},   32'(if1.dout), 32'(e1));
        check_eq({tag, " e1"},   32'(if1.rd_err), 32'(eerr));
        check_eq({tag, " v0@2"}, 32'(if0.rd_valid), 32'd0);
        check_eq({tag, " hold0"}, 32'(if0.dout), 32'(e0));
    endtask

    task automatic count_busy(input string tag, input int exp, input bit poke);
        int cnt = 0;
        while (if0.busy && cnt < 40) begin
            check_eq({tag, " busy1"}, 32'(if1.busy), 32'd1);
            check_eq({tag, " nov0"}, 32'(if0.rd_valid), 32'd0);
            check_eq({tag, " nov1"}, 32'(if1.rd_valid), 32'd0);
            cnt++;
            if (poke) begin
                wr_en = 1'b1; wr_addr = 4'd4; din = 16'h1234;
                rd_en = 1'b1; rd_addr = 4'd4;
                clear_req = cnt[0];
            end
            @(negedge clk);
        end
        idle();
        check_eq({tag, " cycles"}, 32'(cnt), 32'(exp));
        check_eq({tag, " nov0 end"}, 32'(if0.rd_valid), 32'd0);
        check_eq({tag, " nov1 end"}, 32'(if1.rd_valid), 32'd0);
    endtask

    logic [DW-1:0] stream_d [4];

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst busy0", 32'(if0.busy), 32'd1);
        check_eq("rst busy1", 32'(if1.busy), 32'd1);
        check_eq("rst v0", 32'(if0.rd_valid), 32'd0);
        check_eq("rst v1", 32'(if1.rd_valid), 32'd0);
        check_eq("rst err0", 32'(if0.rd_err), 32'd0);
        check_eq("rst dout0", 32'(if0.dout), 32'd0);
        check_eq("rst dout1", 32'(if1.dout), 32'd0);
        rst = 1'b0;
        count_busy("init", DP, 1'b0);

        for (int i = 0; i < DP; i++) begin
            access($sformatf("init rd%0d", i), 1'b0, '0, '0, AW'(i), IV, IV, 1'b0);
        end

        // write then read next cycle
        do_write(4'd3, 16'h1234);
        access("wr-rd", 1'b0, '0, '0, 4'd3, 16'h1234, 16'h1234, 1'b0);

        // back-to-back stream
        stream_d[0] = 16'h1111; stream_d[1] = 16'h2222; stream_d[2] = 16'h3333; stream_d[3] = 16'h1234;
        for (int i = 0; i < 3; i++) do_write(AW'(i), stream_d[i]);
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin rd_en = 1'b1; rd_addr = AW'(j); end
            else rd_en = 1'b0;
            @(negedge clk);
            check_eq($sformatf("strm v0 %0d", j), 32'(if0.rd_valid), 32'(j < 4));
            if (j < 4) check_eq($sformatf("strm d0 %0d", j), 32'(if0.dout), 32'(stream_d[j]));
            check_eq($sformatf("strm v1 %0d", j), 32'(if1.rd_valid), 32'(j >= 1 && j < 5));
            if (j >= 1 && j < 5) check_eq($sformatf("strm d1 %0d", j), 32'(if1.dout), 32'(stream_d[j-1]));
        end
        idle();

        // collision
        do_write(4'd5, 16'h0001);
        access("coll", 1'b1, 4'd5, 16'h00FF, 4'd5, 16'h00FF, 16'h0001, 1'b0);
        access("coll after", 1'b0, '0, '0, 4'd5, 16'h00FF, 16'h00FF, 1'b0);
        access("diff addr", 1'b1, 4'd6, 16'hCAFE, 4'd5, 16'h00FF, 16'h00FF, 1'b0);
        access("rd6", 1'b0, '0, '0, 4'd6, 16'hCAFE, 16'hCAFE, 1'b0);

        // range
        do_write(4'd12, 16'hBEEF);
        access("oor12", 1'b0, '0, '0, 4'd12, 16'h0000, 16'h0000, 1'b1);
        access("oor10", 1'b0, '0, '0, 4'd10, 16'h0000, 16'h0000, 1'b1);
        access("rd2", 1'b0, '0, '0, 4'd2, 16'h3333, 16'h3333, 1'b0);
        access("rd9", 1'b0, '0, '0, 4'd9, IV, IV, 1'b0);

        // clear with a same-cycle write and read, pokes while busy
        clear_req = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd4; din = 16'h7777;
        rd_en = 1'b1; rd_addr = 4'd4;
        @(negedge clk);
        idle();
        count_busy("clear", DP, 1'b1);
        access("clr rd4", 1'b0, '0, '0, 4'd4, IV, IV, 1'b0);
        access("clr rd2", 1'b0, '0, '0, 4'd2, IV, IV, 1'b0);

        // reset with a read in flight, then reset mid-init
        rd_en = 1'b1; rd_addr = 4'd2;
        @(negedge clk);
        idle();
        rst = 1'b1;
        check_eq("flight v0", 32'(if0.rd_valid), 32'd1);
        @(negedge clk);
        check_eq("flight v1", 32'(if1.rd_valid), 32'd0);
        check_eq("flight v0 off", 32'(if0.rd_valid), 32'd0);
        check_eq("flight dout0", 32'(if0.dout), 32'd0);
        check_eq("flight busy", 32'(if0.busy), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("pre busy %0d", i), 32'(if0.busy), 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid rst busy", 32'(if0.busy), 32'd1);
        rst = 1'b0;
        count_busy("restart", DP, 1'b0);
        access("final rd0", 1'b0, '0, '0, 4'd0, IV, IV, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
